mesh_frame_ctrl: RTL and testbench
==================================

Name: mesh_frame_ctrl

Overview:
- Frame sequencer for the 4x4 erosion/dilation mesh.
- The mesh has no enable or stall, so this block is the only source of its 1-bit pixel input.
- Accepts a binary raster with a valid/ready handshake and drives the mesh input every clock, inserting PAD_VAL bubbles whenever no pixel is accepted.
- Tracks each pixel through the fixed mesh latency and emits aligned out_valid/out_last, then flushes the mesh at end of frame.

Parameters:
- WIDTH, 8: pixels per line, >=1.
- HEIGHT, 8: lines per frame, >=1.
- LATENCY, 7: clocks from the mesh input (img) to the mesh output (img_out), >=1.
- PAD_VAL, 0: bit driven into the mesh on bubble and flush cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- in_pixel  in  1  binary input pixel.
- in_valid  in  1  in_pixel is valid.
- in_ready  out  1  block accepts in_pixel this cycle.
- mesh_img  out  1  connects to the mesh img port; registered.
- mesh_img_out  in  1  connects to the mesh img_out port.
- out_pixel  out  1  processed pixel; registered.
- out_valid  out  1  out_pixel is valid.
- out_last  out  1  qualifies the final pixel of the frame.
- busy  out  1  high in STREAM and FLUSH.
- done  out  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset: asynchronous and active-high on rst.
  - state=IDLE; col=0, row=0.
  - Valid/last shift registers cleared.
  - in_ready=0, mesh_img=PAD_VAL, out_pixel=0, out_valid=0, out_last=0, busy=0, done=0.
  - A reset mid-frame abandons the frame; no done pulse is issued.
- Handshake: a pixel is accepted on a cycle where in_valid && in_ready. in_ready is combinational from state (high only in STREAM).
- States:
  - IDLE:
    - mesh_img=PAD_VAL.
    - start -> STREAM; col and row cleared.
  - STREAM:
    - On accept: mesh_img<=in_pixel; tag bit 1 enters the valid shift register; col increments.
    - When col==WIDTH-1: col wraps to 0 and row increments.
    - On a cycle with no accept: mesh_img<=PAD_VAL and tag 0 (bubble). Bubbles never produce out_valid.
    - Accept of pixel (row=HEIGHT-1, col=WIDTH-1): that pixel's last tag=1; next state FLUSH.
  - FLUSH:
    - in_ready=0, mesh_img=PAD_VAL.
    - Down-counter loaded with LATENCY+1; decrements each cycle.
    - When the counter reaches 0 (the cycle out_last is high): next state DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE, including the DONE cycle, is ignored.
- Latency: pixel accepted at edge t.
  - mesh_img carries it from t+1.
  - mesh_img_out carries the result from t+1+LATENCY.
  - out_pixel<=mesh_img_out, so out_valid is high at t+2+LATENCY.
  - Total: LATENCY+2 clocks, constant.
- Tag pipeline: valid and last shift registers of depth LATENCY+1, shifting every clock unconditionally, matching the mesh, which never stalls.
- Output rules:
  - out_valid pulses exactly WIDTH*HEIGHT times per frame.
  - out_last coincides with the final out_valid only.
  - out_pixel holds its registered value when out_valid=0; it is don't-care for checking.
- Boundaries:
  - WIDTH=1: row increments on every accept.
  - WIDTH=HEIGHT=1: first accept goes directly to FLUSH.
  - in_valid held low indefinitely: the block stays in STREAM feeding bubbles; there is no timeout.
- Counter widths: $clog2 of WIDTH, HEIGHT and LATENCY+2, with a minimum of 1 bit each.

Optional Feature:
- Macro: MESH_FRAME_CTRL_FGCOUNT_EN.
- Defined:
  - Adds output port fg_count, width $clog2(WIDTH*HEIGHT+1).
  - Cleared on start; incremented on each out_valid with out_pixel=1.
  - Holds its value after done until the next start. Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
Bench uses a delay-line mock mesh with LATENCY=3, WIDTH=4, HEIGHT=2.
1. Reset while streaming -> all outputs at reset values; mesh_img=PAD_VAL; no done; next start behaves as a fresh frame.
2. start, then 8 back-to-back pixels 1,0,1,1,0,0,1,0 with in_valid constant high -> out_valid high 5 cycles after each accept; same 8 values in order; out_last on the 8th; done 1 cycle after out_last; busy low afterwards.
3. Same frame with in_valid low on every other cycle -> mesh_img=0 in gap cycles; exactly 8 out_valid pulses, each still 5 cycles after its accept.
4. start pulsed during STREAM and again on the DONE cycle -> ignored; the frame completes normally and the block returns to IDLE.
5. WIDTH=HEIGHT=1 with a single pixel 1 -> out_valid=out_last=1 with out_pixel=1 at accept+5; done at accept+6.
6. With MESH_FRAME_CTRL_FGCOUNT_EN and the frame from scenario 2 -> fg_count=4 after done; cleared to 0 on the next start.

Source files
------------

// File: rtl/mesh_frame_ctrl.sv
// ============================================================================
// mesh_frame_ctrl
// ----------------------------------------------------------------------------
// Frame sequencer for the 4x4 erosion/dilation mesh.
// The mesh has no enable or stall, so this block is its only pixel source:
//   - it accepts a binary raster over a valid/ready handshake,
//   - it drives the mesh input every clock, inserting PAD_VAL bubbles on
//     cycles where no pixel is accepted,
//   - it tags every accepted pixel through the fixed mesh latency and emits
//     aligned out_valid/out_last,
//   - it flushes the mesh at end of frame before pulsing done.
//
// Parameters:
//   WIDTH   pixels per line (>=1)
//   HEIGHT  lines per frame (>=1)
//   LATENCY clocks from mesh_img to mesh_img_out (>=1)
//   PAD_VAL bit driven into the mesh on bubble and flush cycles
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous, active-high reset
//   start        one-cycle pulse that begins a frame (honoured only in IDLE)
//   in_pixel     binary input pixel
//   in_valid     in_pixel is valid
//   in_ready     block accepts in_pixel this cycle (high only in STREAM)
//   mesh_img     registered drive to the mesh img port
//   mesh_img_out result from the mesh img_out port
//   out_pixel    registered processed pixel
//   out_valid    out_pixel is valid
//   out_last     qualifies the final pixel of the frame
//   busy         high in STREAM and FLUSH
//   done         one-cycle pulse when the frame completes
//   fg_count     foreground (1) pixel count of the frame; only present when
//                MESH_FRAME_CTRL_FGCOUNT_EN is defined
//
// Optional feature macro: MESH_FRAME_CTRL_FGCOUNT_EN
// ============================================================================
module mesh_frame_ctrl #(
   parameter int   WIDTH   = 8,
   parameter int   HEIGHT  = 8,
   parameter int   LATENCY = 7,
   parameter logic PAD_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic in_pixel,
   input  logic in_valid,
   output logic in_ready,
   output logic mesh_img,
   input  logic mesh_img_out,
   output logic out_pixel,
   output logic out_valid,
   output logic out_last,
   output logic busy,
   output logic done
`ifdef MESH_FRAME_CTRL_FGCOUNT_EN
   ,
   output logic [$clog2(WIDTH*HEIGHT+1)-1:0] fg_count
`endif
);

   localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int CNT_W = ($clog2(LATENCY + 2) > 1) ? $clog2(LATENCY + 2) : 1;

   localparam logic [COL_W-1:0] COL_LAST   = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(HEIGHT - 1);
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      FLUSH,
      DONE
   } state_t;

   state_t             state;
   logic [COL_W-1:0]   col;
   logic [ROW_W-1:0]   row;
   logic [CNT_W-1:0]   flush_cnt;
   logic [LATENCY:0]   vld_sr;
   logic [LATENCY:0]   last_sr;
   logic               accept;
   logic               last_pix;

   // The handshake is purely a function of state so that an upstream source
   // sees ready for the whole STREAM phase and never during flush.
   assign in_ready = (state == STREAM);
   assign accept   = in_valid && in_ready;
   assign last_pix = accept && (col == COL_LAST) && (row == ROW_LAST);

   // Frame sequencer. Walks IDLE -> STREAM -> FLUSH -> DONE -> IDLE, keeps the
   // raster position, and registers the mesh drive plus busy/done.
   // mesh_img defaults to the pad value every cycle and is only overridden
   // by an accepted pixel, which is what turns idle cycles into bubbles.
   // The flush counter is loaded with LATENCY+1 on the last accept; it then
   // reaches zero in exactly the cycle out_last leaves the tag pipeline, so
   // done follows out_last by one clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         col       <= '0;
         row       <= '0;
         flush_cnt <= '0;
         mesh_img  <= PAD_VAL;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         mesh_img <= PAD_VAL;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= STREAM;
                  col   <= '0;
                  row   <= '0;
                  busy  <= 1'b1;
               end
            end
            STREAM: begin
               if (accept) begin
                  mesh_img <= in_pixel;
                  if (col == COL_LAST) begin
                     col <= '0;
                     if (row == ROW_LAST) begin
                        row       <= '0;
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                     end else begin
                        row <= row + 1'b1;
                     end
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (flush_cnt == '0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  flush_cnt <= flush_cnt - 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Tag pipeline shadowing the mesh. Stage 0 lines up with mesh_img and
   // stage LATENCY lines up with mesh_img_out; because the mesh never stalls
   // these registers shift every clock. The output stage then captures the
   // mesh result together with its tags, so bubbles never raise out_valid.
   // out_pixel only updates on real pixels and otherwise holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_sr    <= '0;
         last_sr   <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_pixel <= 1'b0;
      end else begin
         vld_sr    <= {vld_sr[LATENCY-1:0], accept};
         last_sr   <= {last_sr[LATENCY-1:0], last_pix};
         out_valid <= vld_sr[LATENCY];
         out_last  <= last_sr[LATENCY];
         if (vld_sr[LATENCY]) begin
            out_pixel <= mesh_img_out;
         end
      end
   end

`ifdef MESH_FRAME_CTRL_FGCOUNT_EN
   localparam int FG_W = $clog2(WIDTH*HEIGHT + 1);

   // Foreground counter. Cleared when a frame is started and bumped on the
   // same edge that registers a valid output pixel of value 1, so it is
   // final by the done pulse and holds until the next start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fg_count <= '0;
      end else if ((state == IDLE) && start) begin
         fg_count <= '0;
      end else if (vld_sr[LATENCY] && mesh_img_out) begin
         fg_count <= fg_count + FG_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_mesh_frame_ctrl.sv
// ============================================================================
// tb_mesh_frame_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for mesh_frame_ctrl with a delay-line mock mesh.
//   dut  : WIDTH=4, HEIGHT=2, LATENCY=3 (main frames, reset, stray starts,
//          randomised frames against a cycle-indexed reference model)
//   dut1 : WIDTH=1, HEIGHT=1, LATENCY=3 (single-pixel frame corner case)
// When MESH_FRAME_CTRL_FGCOUNT_EN is defined, fg_count is checked as well.
// ============================================================================
module tb_mesh_frame_ctrl;

   localparam int W = 4;
   localparam int H = 2;
   localparam int L = 3;
   localparam int N = W * H;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic start    = 1'b0;
   logic in_pixel = 1'b0;
   logic in_valid = 1'b0;
   logic in_ready, mesh_img, mesh_img_out, out_pixel, out_valid, out_last, busy, done;

   logic start1    = 1'b0;
   logic in_pixel1 = 1'b0;
   logic in_valid1 = 1'b0;
   logic in_ready1, mesh_img1, mesh_img_out1, out_pixel1, out_valid1, out_last1, busy1, done1;

`ifdef MESH_FRAME_CTRL_FGCOUNT_EN
   logic [$clog2(N+1)-1:0] fg_count;
   logic [0:0]             fg_count1;
`endif

   logic [L-1:0] dl;
   logic [L-1:0] dl1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model state: expected events keyed by absolute cycle number
   bit ev_valid [int];
   bit ev_pix   [int];
   bit ev_last  [int];
   bit ev_done  [int];
   bit exp_mesh [int];
   bit m_stream;
   int m_nacc;
   int m_idle_from;
   int m_busy_start;
   int m_busy_end;
   bit mon_en = 1'b0;
   bit ev;
   bit acc;
   int done_cyc;
   int frame_vcnt;
   int frame_ones;

   typedef struct {
      bit [7:0] pix;
      bit       gaps;
      bit       stray;
      int       exp_delay;
      int       exp_ones;
   } vec_t;

   vec_t vecs [4];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mesh_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .LATENCY(L), .PAD_VAL(1'b0)) dut (
      .clk(clk), .rst(rst), .start(start), .in_pixel(in_pixel), .in_valid(in_valid),
      .in_ready(in_ready), .mesh_img(mesh_img), .mesh_img_out(mesh_img_out),
      .out_pixel(out_pixel), .out_valid(out_valid), .out_last(out_last),
      .busy(busy), .done(done)
`ifdef MESH_FRAME_CTRL_FGCOUNT_EN
      , .fg_count(fg_count)
`endif
   );

   mesh_frame_ctrl #(.WIDTH(1), .HEIGHT(1), .LATENCY(L), .PAD_VAL(1'b0)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .in_pixel(in_pixel1), .in_valid(in_valid1),
      .in_ready(in_ready1), .mesh_img(mesh_img1), .mesh_img_out(mesh_img_out1),
      .out_pixel(out_pixel1), .out_valid(out_valid1), .out_last(out_last1),
      .busy(busy1), .done(done1)
`ifdef MESH_FRAME_CTRL_FGCOUNT_EN
      , .fg_count(fg_count1)
`endif
   );

   // Mock meshes: identity function with a fixed LATENCY-deep delay line
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         dl  <= '0;
         dl1 <= '0;
      end else begin
         dl  <= {dl[L-2:0], mesh_img};
         dl1 <= {dl1[L-2:0], mesh_img1};
      end
   end
   assign mesh_img_out  = dl[L-1];
   assign mesh_img_out1 = dl1[L-1];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic modelReset();
      ev_valid.delete();
      ev_pix.delete();
      ev_last.delete();
      ev_done.delete();
      exp_mesh.delete();
      m_stream     = 1'b0;
      m_nacc       = 0;
      m_idle_from  = 0;
      m_busy_start = 1;
      m_busy_end   = 0;
   endtask

   // Cycle-level reference: a pixel accepted in cycle c appears on mesh_img
   // in c+1, on out_valid in c+L+2; the final pixel also schedules done at
   // c+L+3 and the block is idle again from c+L+4.
   always @(negedge clk) begin
      if (!rst && mon_en) begin
         checkOutput("in_ready", in_ready, m_stream);
         checkOutput("busy", busy, (cyc >= m_busy_start) && (cyc <= m_busy_end));
         checkOutput("mesh_img", mesh_img, exp_mesh.exists(cyc) ? exp_mesh[cyc] : 1'b0);
         ev = ev_valid.exists(cyc);
         checkOutput("out_valid", out_valid, ev);
         checkOutput("out_last", out_last, ev_last.exists(cyc));
         if (ev) begin
            checkOutput("out_pixel", out_pixel, ev_pix[cyc]);
         end
         checkOutput("done", done, ev_done.exists(cyc));
         if (out_valid === 1'b1) frame_vcnt++;
         if (out_valid === 1'b1 && out_pixel === 1'b1) frame_ones++;
         if (done === 1'b1) done_cyc = cyc;
         acc = m_stream && in_valid;
         if (acc) begin
            exp_mesh[cyc+1]   = in_pixel;
            ev_valid[cyc+L+2] = 1'b1;
            ev_pix[cyc+L+2]   = in_pixel;
            m_nacc++;
            if (m_nacc == N) begin
               ev_last[cyc+L+2] = 1'b1;
               ev_done[cyc+L+3] = 1'b1;
               m_busy_end       = cyc + L + 2;
               m_idle_from      = cyc + L + 4;
               m_stream         = 1'b0;
            end
         end else if (!m_stream && start && cyc >= m_idle_from) begin
            m_stream     = 1'b1;
            m_nacc       = 0;
            m_busy_start = cyc + 1;
            m_busy_end   = 32'h7fffffff;
         end
      end
   end

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_in_ready"}, in_ready, 1'b0);
      checkOutput({tag, "_mesh_img"}, mesh_img, 1'b0);
      checkOutput({tag, "_out_pixel"}, out_pixel, 1'b0);
      checkOutput({tag, "_out_valid"}, out_valid, 1'b0);
      checkOutput({tag, "_out_last"}, out_last, 1'b0);
      checkOutput({tag, "_busy"}, busy, 1'b0);
      checkOutput({tag, "_done"}, done, 1'b0);
   endtask

   task automatic waitDone(input int s, input bit stray, input int stray_cyc, output int delay);
      int guard;
      guard = 0;
      while (done_cyc < 0 && guard < 60) begin
         start = stray && (cyc == s + stray_cyc);
         tick();
         guard++;
      end
      start = 1'b0;
      if (done_cyc < 0) begin
         checkOutput("done_timeout", 0, 1);
         delay = -1;
      end else begin
         delay = done_cyc - s;
      end
   endtask

   // One table-driven frame: start, 8 pixels (optionally with a gap cycle
   // after each), optional stray starts in STREAM and on the DONE cycle.
   task automatic applyStimulus(input vec_t v, output int delay);
      int s;
      frame_vcnt = 0;
      frame_ones = 0;
      done_cyc   = -1;
      start = 1'b1;
      s = cyc;
      tick();
      start = 1'b0;
`ifdef MESH_FRAME_CTRL_FGCOUNT_EN
      checkOutput("fg_count_cleared", fg_count, 0);
`endif
      for (int k = 0; k < N; k++) begin
         in_valid = 1'b1;
         in_pixel = v.pix[k];
         start    = v.stray && (k == 2);
         tick();
         start    = 1'b0;
         in_valid = 1'b0;
         if (v.gaps) begin
            in_pixel = 1'b1;
            tick();
         end
      end
      in_pixel = 1'b0;
      waitDone(s, v.stray, v.exp_delay, delay);
   endtask

   // Randomised frame: random valid gaps, random pixels and stray starts.
   task automatic applyRandomStimulus(input int idx);
      int s;
      int guard;
      int delay;
      frame_vcnt = 0;
      done_cyc   = -1;
      start = 1'b1;
      s = cyc;
      tick();
      guard = 0;
      while (!(m_nacc == N && !m_stream) && guard < 300) begin
         in_valid = 1'($urandom_range(0, 1));
         in_pixel = 1'($urandom_range(0, 1));
         start    = ($urandom_range(0, 7) == 0);
         tick();
         guard++;
      end
      in_valid = 1'b0;
      in_pixel = 1'b0;
      start    = 1'b0;
      if (guard >= 300) checkOutput($sformatf("rnd%0d_feed_timeout", idx), 0, 1);
      waitDone(s, 1'b0, 0, delay);
      checkOutput($sformatf("rnd%0d_valid_count", idx), frame_vcnt, N);
      repeat (2) tick();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish (errors so far %0d)", errors);
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int delay;
      int c;
      int s;

      vecs[0] = '{pix: 8'h4D, gaps: 1'b0, stray: 1'b0, exp_delay: 14, exp_ones: 4};
      vecs[1] = '{pix: 8'h4D, gaps: 1'b1, stray: 1'b0, exp_delay: 21, exp_ones: 4};
      vecs[2] = '{pix: 8'hB2, gaps: 1'b0, stray: 1'b1, exp_delay: 14, exp_ones: 4};
      vecs[3] = '{pix: 8'hFF, gaps: 1'b1, stray: 1'b0, exp_delay: 21, exp_ones: 8};

      modelReset();
      #1 rst = 1'b1;
      #1;
      checkResetValues("por");
      tick();
      tick();
      rst = 1'b0;
      modelReset();
      mon_en = 1'b1;
      repeat (2) tick();

      $display("[TB] reset while streaming");
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_pixel = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkResetValues("midrst");
      tick();
      tick();
      rst = 1'b0;
      modelReset();
      repeat (12) tick();

      $display("[TB] table-driven frames");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(vecs[i], delay);
         checkOutput($sformatf("vec%0d_done_delay", i), delay, vecs[i].exp_delay);
         checkOutput($sformatf("vec%0d_valid_count", i), frame_vcnt, N);
         checkOutput($sformatf("vec%0d_ones", i), frame_ones, vecs[i].exp_ones);
`ifdef MESH_FRAME_CTRL_FGCOUNT_EN
         checkOutput($sformatf("vec%0d_fg_count", i), fg_count, vecs[i].exp_ones);
`endif
         repeat (3) tick();
      end

      $display("[TB] randomised frames");
      for (int i = 0; i < 6; i++) begin
         applyRandomStimulus(i);
      end

      $display("[TB] single-pixel frame");
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      s = cyc;
      in_valid1 = 1'b1;
      in_pixel1 = 1'b1;
      c = cyc;
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         checkOutput($sformatf("w1_ready_%0d", k), in_ready1, (k == 0));
         checkOutput($sformatf("w1_mesh_%0d", k), mesh_img1, (k == 1));
         checkOutput($sformatf("w1_valid_%0d", k), out_valid1, (k == 5));
         checkOutput($sformatf("w1_last_%0d", k), out_last1, (k == 5));
         checkOutput($sformatf("w1_done_%0d", k), done1, (k == 6));
         checkOutput($sformatf("w1_busy_%0d", k), busy1, (k <= 5));
         if (k == 5) begin
            checkOutput("w1_pixel", out_pixel1, 1);
         end
         tick();
         in_valid1 = 1'b0;
         in_pixel1 = 1'b0;
      end
`ifdef MESH_FRAME_CTRL_FGCOUNT_EN
      checkOutput("w1_fg_count", fg_count1, 1);
`endif
      checkOutput("w1_cycle_base", c - s, 0);

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
